// File: rtl/cla_seq_adder_pkg.sv
// Package: cla_seq_adder_pkg
// Purpose: shared constants, FSM state type and sizing helper for the
//          multi-cycle carry-lookahead adder (cla_seq_adder) and its
//          16-bit combinational slice (cla16_slice).
// Contents:
//   SLICE_W     width of one carry-lookahead pass (16)
//   GROUP_W     width of one lookahead group (4)
//   state_e     FSM states ST_IDLE / ST_RUN / ST_DONE
//   cnt_width() pass-counter width, never less than 1 bit
package cla_seq_adder_pkg;

  localparam int SLICE_W = 16;
  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for n passes; a single-pass build still needs one bit.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cla_seq_adder_cla16_slice.sv
// Module: cla16_slice
// Purpose: combinational 16-bit carry-lookahead adder built from four 4-bit
//          group propagate/generate units and one 4-group lookahead
//          generator.
// Ports:
//   a   [15:0] in   operand A slice
//   b   [15:0] in   operand B slice
//   ci         in   carry into bit 0
//   s   [15:0] out  sum
//   c15        out  carry into bit 15 (for signed overflow)
//   c16        out  carry out of bit 15
module cla16_slice
  import cla_seq_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               c15,
  output logic               c16
);

  localparam int NGRP = SLICE_W / GROUP_W;

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic [NGRP-1:0]    w_gp;
  logic [NGRP-1:0]    w_gg;
  logic [NGRP:0]      w_gc;
  logic [SLICE_W:0]   w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Group propagate/generate for each 4-bit group.
  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int i = 0; i < NGRP; i++) begin
      w_gp[i] = &w_p[GROUP_W*i +: GROUP_W];
      w_gg[i] = w_g[GROUP_W*i+3]
              | (w_p[GROUP_W*i+3] & w_g[GROUP_W*i+2])
              | (w_p[GROUP_W*i+3] & w_p[GROUP_W*i+2] & w_g[GROUP_W*i+1])
              | ((&w_p[GROUP_W*i+1 +: 3]) & w_g[GROUP_W*i]);
    end
  end

  // 4-group lookahead generator: every group carry-in straight from ci.
  always_comb begin
    w_gc[0] = ci;
    w_gc[1] = w_gg[0] | (w_gp[0] & ci);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & ci);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & ci);
    w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & ci);
  end

  // Bit carries inside each group, seeded by the lookahead group carry.
  always_comb begin
    logic [SLICE_W:0] c;
    c = '0;
    for (int i = 0; i < NGRP; i++) begin
      c[GROUP_W*i] = w_gc[i];
      for (int j = 0; j < GROUP_W-1; j++) begin
        c[GROUP_W*i+j+1] = w_g[GROUP_W*i+j] | (w_p[GROUP_W*i+j] & c[GROUP_W*i+j]);
      end
    end
    c[SLICE_W] = w_gc[NGRP];
    w_c = c;
  end

  assign s   = w_p ^ w_c[SLICE_W-1:0];
  assign c15 = w_c[SLICE_W-1];
  assign c16 = w_c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Module: cla_seq_adder
// Purpose: WIDTH-bit adder that reuses one 16-bit carry-lookahead slice for
//          WIDTH/16 passes, carrying between passes through a register.
//          Valid/ready handshake on both sides; one add in flight.
// Optional feature: define CLA_SEQ_SUB_EN to add the 'sub' port (A-B).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin [, sub])
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   sum, cout, ovf      result, carry out of MSB, signed overflow
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = cnt_width(NSLICE);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a non-zero multiple of 16");
  end

  state_e             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cout;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [SLICE_W-1:0] w_s;
  logic               w_c15;
  logic               w_c16;
  logic [WIDTH-1:0]   w_sum_nxt;
  logic [WIDTH-1:0]   w_b_cap;
  logic               w_carry_cap;

  cla16_slice u_slice (
    .a   (r_a_sh[SLICE_W-1:0]),
    .b   (r_b_sh[SLICE_W-1:0]),
    .ci  (r_carry),
    .s   (w_s),
    .c15 (w_c15),
    .c16 (w_c16)
  );

  // Sum shifts right one slice per pass; the fresh slice lands at the top.
  always_comb begin
    w_sum_nxt = r_sum >> SLICE_W;
    w_sum_nxt[WIDTH-1 -: SLICE_W] = w_s;
  end

  // Operand B and initial carry as captured at acceptance.
`ifdef CLA_SEQ_SUB_EN
  always_comb begin
    if (sub) begin
      w_b_cap     = ~b;
      w_carry_cap = 1'b1;
    end else begin
      w_b_cap     = b;
      w_carry_cap = cin;
    end
  end
`else
  always_comb begin
    w_b_cap     = b;
    w_carry_cap = cin;
  end
`endif

  // Sequencer FSM, datapath registers and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= w_b_cap;
            r_carry    <= w_carry_cap;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum   <= w_sum_nxt;
          r_a_sh  <= r_a_sh >> SLICE_W;
          r_b_sh  <= r_b_sh >> SLICE_W;
          r_carry <= w_c16;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(NSLICE-1)) begin
            r_cout      <= w_c16;
            r_ovf       <= w_c15 ^ w_c16;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
